// File: rtl/y86_pkg.sv
// Shared Y86 definitions: stat codes, register IDs, write-back FSM states.
package y86_pkg;

  localparam int unsigned REG_W  = 64;
  localparam int unsigned NREGS  = 15;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STAT_W = 3;

  localparam logic [STAT_W-1:0] SBUB = 3'd0;
  localparam logic [STAT_W-1:0] SAOK = 3'd1;
  localparam logic [STAT_W-1:0] SHLT = 3'd2;
  localparam logic [STAT_W-1:0] SADR = 3'd3;
  localparam logic [STAT_W-1:0] SINS = 3'd4;

  localparam logic [ID_W-1:0] RRAX  = 4'h0;
  localparam logic [ID_W-1:0] RRCX  = 4'h1;
  localparam logic [ID_W-1:0] RRDX  = 4'h2;
  localparam logic [ID_W-1:0] RRBX  = 4'h3;
  localparam logic [ID_W-1:0] RRSP  = 4'h4;
  localparam logic [ID_W-1:0] RRBP  = 4'h5;
  localparam logic [ID_W-1:0] RRSI  = 4'h6;
  localparam logic [ID_W-1:0] RRDI  = 4'h7;
  localparam logic [ID_W-1:0] RR8   = 4'h8;
  localparam logic [ID_W-1:0] RR9   = 4'h9;
  localparam logic [ID_W-1:0] RR10  = 4'hA;
  localparam logic [ID_W-1:0] RR11  = 4'hB;
  localparam logic [ID_W-1:0] RR12  = 4'hC;
  localparam logic [ID_W-1:0] RR13  = 4'hD;
  localparam logic [ID_W-1:0] RR14  = 4'hE;
  localparam logic [ID_W-1:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // IDs outside the array, and the "no destination" ID, never address a register.
  function automatic logic id_valid(input logic [ID_W-1:0] id,
                                    input logic [ID_W-1:0] none_id);
    return (id != none_id) && (32'(id) < NREGS);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back stage and decode read-port bundle of the Y86 register file.
interface wb_regfile_if;
  import y86_pkg::*;

  logic [STAT_W-1:0] W_stat;
  logic [ID_W-1:0]   W_icode;
  logic [ID_W-1:0]   W_dstE;
  logic [ID_W-1:0]   W_dstM;
  logic [REG_W-1:0]  W_valE;
  logic [REG_W-1:0]  W_valM;
  logic [ID_W-1:0]   d_srcA;
  logic [ID_W-1:0]   d_srcB;
  logic [REG_W-1:0]  d_rvalA;
  logic [REG_W-1:0]  d_rvalB;

  modport master (
    output W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB
  );

  modport slave (
    input  W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB
  );
endinterface

// File: rtl/regfile_2w2r.sv
// 15 x 64-bit register array, two write ports (M over E), two combinational reads.
// Optional same-cycle write-to-read bypass under WB_BYPASS_EN.
module regfile_2w2r
  import y86_pkg::*;
#(
  parameter logic [ID_W-1:0] NONE_ID = RNONE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_e_i,
  input  logic [ID_W-1:0]              dst_e_i,
  input  logic [REG_W-1:0]             val_e_i,
  input  logic                         we_m_i,
  input  logic [ID_W-1:0]              dst_m_i,
  input  logic [REG_W-1:0]             val_m_i,
  input  logic [ID_W-1:0]              src_a_i,
  input  logic [ID_W-1:0]              src_b_i,
  output logic [REG_W-1:0]             rval_a_o,
  output logic [REG_W-1:0]             rval_b_o,
  output logic [NREGS-1:0][REG_W-1:0]  regs_o
);

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [NREGS-1:0][REG_W-1:0] regs_q, regs_d;

  // M port applied last so it wins on a shared destination.
  always_comb begin
    regs_d = regs_q;
    if (we_e_i) regs_d[dst_e_i] = val_e_i;
    if (we_m_i) regs_d[dst_m_i] = val_m_i;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  always_comb begin
    rval_a_o = '0;
    if (id_valid(src_a_i, NONE_ID)) rval_a_o = regs_q[src_a_i];
    if (BYPASS && we_m_i && (dst_m_i == src_a_i))      rval_a_o = val_m_i;
    else if (BYPASS && we_e_i && (dst_e_i == src_a_i)) rval_a_o = val_e_i;
  end

  always_comb begin
    rval_b_o = '0;
    if (id_valid(src_b_i, NONE_ID)) rval_b_o = regs_q[src_b_i];
    if (BYPASS && we_m_i && (dst_m_i == src_b_i))      rval_b_o = val_m_i;
    else if (BYPASS && we_e_i && (dst_e_i == src_b_i)) rval_b_o = val_e_i;
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/wb_regfile.sv
// Y86 write-back register file: RUN/HALT/FAULT status FSM plus saturating retire counter.
// Build option WB_BYPASS_EN enables same-cycle write-to-read bypass in the array.
module wb_regfile
  import y86_pkg::*;
#(
  parameter int unsigned      RETIRE_W = 32,
  parameter logic [ID_W-1:0]  RNONE    = y86_pkg::RNONE
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_regfile_if.slave          bus,
  output logic [STAT_W-1:0]    stat_o,
  output logic                 halted_o,
  output logic [RETIRE_W-1:0]  retired_o,
  output logic [REG_W-1:0]     rax,
  output logic [REG_W-1:0]     rcx,
  output logic [REG_W-1:0]     rdx,
  output logic [REG_W-1:0]     rbx,
  output logic [REG_W-1:0]     rsp,
  output logic [REG_W-1:0]     rbp,
  output logic [REG_W-1:0]     rsi,
  output logic [REG_W-1:0]     rdi,
  output logic [REG_W-1:0]     r8,
  output logic [REG_W-1:0]     r9,
  output logic [REG_W-1:0]     r10,
  output logic [REG_W-1:0]     r11,
  output logic [REG_W-1:0]     r12,
  output logic [REG_W-1:0]     r13,
  output logic [REG_W-1:0]     r14
);

  state_e                state_q, state_d;
  logic [STAT_W-1:0]     code_q, code_d;
  logic [STAT_W-1:0]     stat_q, stat_d;
  logic                  halted_q, halted_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  retire_c, aok_run_c, we_e_c, we_m_c;
  logic [NREGS-1:0][REG_W-1:0] regs_c;
  logic                  unused_icode;

  assign unused_icode = ^bus.W_icode;

  assign aok_run_c = (state_q == ST_RUN) && (bus.W_stat == SAOK);
  assign we_e_c    = aok_run_c && id_valid(bus.W_dstE, RNONE);
  assign we_m_c    = aok_run_c && id_valid(bus.W_dstM, RNONE);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    retired_d = retired_q;
    retire_c  = 1'b0;
    stat_d    = SAOK;
    unique case (state_q)
      ST_RUN: begin
        unique case (bus.W_stat)
          SAOK: retire_c = 1'b1;
          SHLT: begin
            retire_c = 1'b1;
            state_d  = ST_HALT;
          end
          SADR, SINS: begin
            state_d = ST_FAULT;
            code_d  = bus.W_stat;
          end
          default: ;
        endcase
      end
      ST_HALT, ST_FAULT: ;
      default: state_d = ST_RUN;
    endcase
    if (retire_c && (retired_q != {RETIRE_W{1'b1}})) retired_d = retired_q + RETIRE_W'(1);
    // Architectural status is registered alongside the state it reflects.
    unique case (state_d)
      ST_HALT:  stat_d = SHLT;
      ST_FAULT: stat_d = code_d;
      default:  stat_d = SAOK;
    endcase
    halted_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      code_q    <= '0;
      stat_q    <= SAOK;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      stat_q    <= stat_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  regfile_2w2r #(.NONE_ID(RNONE)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_e_i   (we_e_c),
    .dst_e_i  (bus.W_dstE),
    .val_e_i  (bus.W_valE),
    .we_m_i   (we_m_c),
    .dst_m_i  (bus.W_dstM),
    .val_m_i  (bus.W_valM),
    .src_a_i  (bus.d_srcA),
    .src_b_i  (bus.d_srcB),
    .rval_a_o (bus.d_rvalA),
    .rval_b_o (bus.d_rvalB),
    .regs_o   (regs_c)
  );

  assign stat_o    = stat_q;
  assign halted_o  = halted_q;
  assign retired_o = retired_q;

  assign rax = regs_c[0];
  assign rcx = regs_c[1];
  assign rdx = regs_c[2];
  assign rbx = regs_c[3];
  assign rsp = regs_c[4];
  assign rbp = regs_c[5];
  assign rsi = regs_c[6];
  assign rdi = regs_c[7];
  assign r8  = regs_c[8];
  assign r9  = regs_c[9];
  assign r10 = regs_c[10];
  assign r11 = regs_c[11];
  assign r12 = regs_c[12];
  assign r13 = regs_c[13];
  assign r14 = regs_c[14];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random write-back traffic vs. a reference model.
module tb_wb_regfile;

  localparam int RW   = 5;
  localparam int RMAX = (1 << RW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_regfile_if bus();

  logic [2:0]    stat_o;
  logic          halted_o;
  logic [RW-1:0] retired_o;
  logic [63:0]   rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8, r9, r10, r11, r12, r13, r14;
  logic [63:0]   obs_reg [15];

  wb_regfile #(.RETIRE_W(RW), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stat_o(stat_o), .halted_o(halted_o), .retired_o(retired_o),
    .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp), .rsi(rsi), .rdi(rdi),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14)
  );

  assign obs_reg[0]  = rax;  assign obs_reg[1]  = rcx;  assign obs_reg[2]  = rdx;
  assign obs_reg[3]  = rbx;  assign obs_reg[4]  = rsp;  assign obs_reg[5]  = rbp;
  assign obs_reg[6]  = rsi;  assign obs_reg[7]  = rdi;  assign obs_reg[8]  = r8;
  assign obs_reg[9]  = r9;   assign obs_reg[10] = r10;  assign obs_reg[11] = r11;
  assign obs_reg[12] = r12;  assign obs_reg[13] = r13;  assign obs_reg[14] = r14;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: architectural registers, status value (1 run, 2 halt, 3/4 fault), retire count.
  logic [63:0] mreg [15];
  int          mst;
  int          mret;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_read(input logic [3:0] id, input logic [2:0] st,
                                           input logic [3:0] de, input logic [63:0] ve,
                                           input logic [3:0] dm, input logic [63:0] vm);
    logic writing;
    writing = (mst == 1) && (st == 3'd1);
    if (BYP && writing && dm != 4'hF && dm == id) return vm;
    if (BYP && writing && de != 4'hF && de == id) return ve;
    if (id == 4'hF) return 64'd0;
    return mreg[id];
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] st, input logic [3:0] de,
                            input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    if (r) begin
      for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
      mst = 1;
      mret = 0;
    end else if (mst == 1) begin
      if (st == 3'd1) begin
        if (de != 4'hF) mreg[de] = ve;
        if (dm != 4'hF) mreg[dm] = vm;
        mret = (mret < RMAX) ? mret + 1 : RMAX;
      end else if (st == 3'd2) begin
        mst = 2;
        mret = (mret < RMAX) ? mret + 1 : RMAX;
      end else if (st == 3'd3 || st == 3'd4) begin
        mst = int'(st);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":stat"}, 64'(stat_o), 64'(mst));
    chk({tag, ":halted"}, 64'(halted_o), 64'(mst != 1));
    chk({tag, ":retired"}, 64'(retired_o), 64'(mret));
    for (int i = 0; i < 15; i++) chk($sformatf("%s:r%0d", tag, i), obs_reg[i], mreg[i]);
  endtask

  // One write-back cycle: drive, check decode reads before the edge, advance model after it.
  task automatic step(input logic r, input logic [2:0] st, input logic [3:0] de,
                      input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm,
                      input logic [3:0] sa, input logic [3:0] sb);
    rst = r;
    bus.W_stat = st; bus.W_icode = 4'($urandom_range(0, 15));
    bus.W_dstE = de; bus.W_valE = ve; bus.W_dstM = dm; bus.W_valM = vm;
    bus.d_srcA = sa; bus.d_srcB = sb;
    #1;
    if (!r) begin
      chk("rvalA", bus.d_rvalA, exp_read(sa, st, de, ve, dm, vm));
      chk("rvalB", bus.d_rvalB, exp_read(sb, st, de, ve, dm, vm));
    end
    @(posedge clk); #1;
    model_edge(r, st, de, ve, dm, vm);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] rand_id();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  function automatic logic [2:0] rand_stat();
    int p;
    p = int'($urandom_range(0, 99));
    if (p < 45) return 3'd1;
    if (p < 90) return 3'd0;
    if (p < 94) return 3'd2;
    if (p < 97) return 3'd3;
    return 3'd4;
  endfunction

  initial begin
    int term;
    logic [63:0] v;
    bus.W_stat = 3'd0; bus.W_icode = 4'd0; bus.W_dstE = 4'hF; bus.W_dstM = 4'hF;
    bus.W_valE = 64'd0; bus.W_valM = 64'd0; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    for (int i = 0; i < 15; i++) mreg[i] = 64'hx;
    mst = 0; mret = 0;
    @(posedge clk); #1;

    // Reset state
    step(1'b1, 3'd0, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF);
    chk("rst_stat", 64'(stat_o), 64'd1);
    chk("rst_halted", 64'(halted_o), 64'd0);
    chk("rst_retired", 64'(retired_o), 64'd0);
    check_all("reset");

    // AOK E-port write, M port RNONE
    step(1'b0, 3'd1, 4'h0, 64'd5, 4'hF, 64'hDEAD, 4'h0, 4'hF);
    chk("aok_rax", rax, 64'd5);
    chk("aok_retired", 64'(retired_o), 64'd1);
    chk("aok_stat", 64'(stat_o), 64'd1);

    // Shared destination: M wins
    step(1'b0, 3'd1, 4'h4, 64'd8, 4'h4, 64'h100, 4'h4, 4'h0);
    chk("mwins_rsp", rsp, 64'h100);
    check_all("mwins");

    // Same-cycle write/read of rdx, then read of invalid ID
    bus.W_stat = 3'd1; bus.W_dstE = 4'h2; bus.W_valE = 64'd9; bus.W_dstM = 4'hF;
    bus.W_valM = 64'd0; bus.d_srcA = 4'h2; bus.d_srcB = 4'hF;
    #1;
    chk("bypass_rvalA", bus.d_rvalA, BYP ? 64'd9 : 64'd0);
    chk("rnone_rvalB", bus.d_rvalB, 64'd0);
    @(posedge clk); #1;
    model_edge(1'b0, 3'd1, 4'h2, 64'd9, 4'hF, 64'd0);
    chk("after_rvalA", bus.d_rvalA, 64'd9);
    chk("after_rdx", rdx, 64'd9);

    // HLT then suppressed AOK
    step(1'b1, 3'd0, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF);
    step(1'b0, 3'd2, 4'h3, 64'd1, 4'hF, 64'd0, 4'h3, 4'hF);
    step(1'b0, 3'd1, 4'h3, 64'd7, 4'hF, 64'd0, 4'h3, 4'hF);
    chk("hlt_stat", 64'(stat_o), 64'd2);
    chk("hlt_halted", 64'(halted_o), 64'd1);
    chk("hlt_rbx", rbx, 64'd0);
    chk("hlt_retired", 64'(retired_o), 64'd1);

    // ADR fault, later INS ignored, then reset recovers
    step(1'b1, 3'd0, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF);
    step(1'b0, 3'd3, 4'h1, 64'h55, 4'hF, 64'd0, 4'h1, 4'hF);
    chk("adr_rcx", rcx, 64'd0);
    chk("adr_stat", 64'(stat_o), 64'd3);
    chk("adr_retired", 64'(retired_o), 64'd0);
    step(1'b0, 3'd4, 4'h1, 64'h66, 4'hF, 64'd0, 4'h1, 4'hF);
    chk("adr_sticky_stat", 64'(stat_o), 64'd3);
    step(1'b0, 3'd1, 4'h5, 64'h77, 4'h6, 64'h88, 4'h5, 4'h6);
    step(1'b1, 3'd1, 4'h1, 64'h99, 4'h2, 64'hAA, 4'hF, 4'hF);
    chk("fault_rst_stat", 64'(stat_o), 64'd1);
    chk("fault_rst_halted", 64'(halted_o), 64'd0);
    for (int i = 0; i < 15; i++) chk($sformatf("fault_rst_r%0d", i), obs_reg[i], 64'd0);

    // Retire counter saturation
    for (int i = 0; i < RMAX; i++) step(1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF);
    chk("sat_full", 64'(retired_o), 64'(RMAX));
    step(1'b0, 3'd1, 4'h7, 64'h1234, 4'hF, 64'd0, 4'h7, 4'hF);
    chk("sat_hold", 64'(retired_o), 64'(RMAX));
    chk("sat_rdi", rdi, 64'h1234);

    // Random traffic against the model
    step(1'b1, 3'd0, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF);
    term = 0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = 1'b0;
      if (mst != 1) term++;
      if (term >= 4 || $urandom_range(0, 99) == 0) begin
        r = 1'b1;
        term = 0;
      end
      v = {$urandom, $urandom};
      step(r, rand_stat(), rand_id(), v, rand_id(), {$urandom, $urandom},
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check_all($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
